// File: rtl/config_loader_pkg.sv
// config_loader_pkg
// Shared definitions for the serial configuration loader and the
// control_connection_block it feeds: the loader FSM state encoding and
// the helpers that size a select field and the whole select word from
// the track count W and the number of control inputs.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Bits needed to pick one of 2*W candidate tracks.
  function automatic int sel_per_in(input int w);
    return $clog2(2 * w);
  endfunction

  // Total select-word width for all control inputs.
  function automatic int cfg_bits(input int w, input int controlin);
    return sel_per_in(w) * controlin;
  endfunction

endpackage

// File: rtl/config_loader_if.sv
// config_loader_if
// Serial configuration bus between a configuration source (master) and
// the loader (slave).
//   cfg_start  master->slave  one-cycle request to begin a new load
//   cfg_valid  master->slave  cfg_bit is valid this cycle
//   cfg_bit    master->slave  serial configuration bit, LSB of field 0 first
//   cfg_ready  slave->master  loader accepts a bit this cycle
//   c          slave->master  committed select word
//   cfg_done   slave->master  one-cycle pulse on successful commit
//   cfg_err    slave->master  sticky: last load rejected
//   busy       slave->master  loader is not idle
interface config_loader_if #(
  parameter int CFG_BITS = 12
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_bit;
  logic                cfg_ready;
  logic [CFG_BITS-1:0] c;
  logic                cfg_done;
  logic                cfg_err;
  logic                busy;

  modport master (
    output cfg_start, cfg_valid, cfg_bit,
    input  cfg_ready, c, cfg_done, cfg_err, busy
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit,
    output cfg_ready, c, cfg_done, cfg_err, busy
  );
endinterface

// File: rtl/config_loader_cfg_field_check.sv
// cfg_field_check
// Combinational legality check of a fully shifted select word: flags any
// field whose value does not address one of the 2*W candidate tracks.
//   shadow  in   CFG_BITS  shifted select word, field i at [i*SEL_PER_IN +: SEL_PER_IN]
//   bad     out  1         some field >= 2*W
module cfg_field_check
  import config_loader_pkg::*;
#(
  parameter  int W          = 7,
  parameter  int CONTROLIN  = 3,
  localparam int SEL_PER_IN = sel_per_in(W),
  localparam int CFG_BITS   = cfg_bits(W, CONTROLIN)
) (
  input  logic [CFG_BITS-1:0] shadow,
  output logic                bad
);

  // One extra bit so the limit still fits when 2*W is a power of two.
  localparam logic [SEL_PER_IN:0] LIMIT = (SEL_PER_IN + 1)'(2 * W);

  // OR together the out-of-range flag of every field.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < CONTROLIN; i++) begin
      if ({1'b0, shadow[i*SEL_PER_IN +: SEL_PER_IN]} >= LIMIT) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// config_loader
// Shifts a select word in serially, checks every field addresses a real
// track, and only then commits it to c for the control_connection_block.
// A rejected word leaves c untouched and raises the sticky cfg_err.
//   clk    in     sole clock, rising edge
//   rst_n  in     asynchronous active-low reset
//   bus    slave  serial configuration bus (see config_loader_if)
module config_loader
  import config_loader_pkg::*;
#(
  parameter  int W          = 7,
  parameter  int CONTROLIN  = 3,
  localparam int CFG_BITS   = cfg_bits(W, CONTROLIN),
  localparam int CW         = $clog2(CFG_BITS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  config_loader_if.slave  bus
);

  localparam logic [CW-1:0] LAST = CW'(CFG_BITS - 1);

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cnt;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] c_q;
  logic                done_q;
  logic                err_q;
  logic                accept;
  logic                field_bad;

  cfg_field_check #(
    .W         (W),
    .CONTROLIN (CONTROLIN)
  ) u_check (
    .shadow (shadow),
    .bad    (field_bad)
  );

  // ready and busy are pure state decodes so they change with the state.
  assign bus.cfg_ready = (state == SHIFT);
  assign bus.busy      = (state != IDLE);
  assign bus.c         = c_q;
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and bit-acceptance decode; a restart in SHIFT wins over a valid bit.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cfg_start) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (bus.cfg_start) begin
          state_next = SHIFT;
        end else if (bus.cfg_valid) begin
          accept = 1'b1;
          if (cnt == LAST) begin
            state_next = CHECK;
          end else begin
            state_next = SHIFT;
          end
        end else begin
          state_next = SHIFT;
        end
      end
      CHECK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shadow shift, bit counter, commit and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            cnt    <= '0;
            shadow <= '0;
            err_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.cfg_start) begin
            cnt    <= '0;
            shadow <= '0;
          end else if (accept) begin
            shadow[cnt] <= bus.cfg_bit;
            cnt         <= cnt + CW'(1);
          end
        end
        CHECK: begin
          if (field_bad) begin
            err_q <= 1'b1;
          end else begin
            c_q    <= shadow;
            done_q <= 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
